// File: rtl/la_cap_pkg.sv
// Shared types for the logic-analyzer capture controller.
package la_cap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POSTTRIG,
    DONE
  } cap_state_t;

  localparam int TO_W = 16;

endpackage

// File: rtl/capture_ctrl_wrap_ctr.sv
// Modulo-MOD up-counter; clr has priority over inc, wraps MOD-1 -> 0.
module wrap_ctr #(
  parameter int MOD = 16,
  parameter int W   = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: pre-trigger fill, arm, post-trigger count into a circular sample RAM.
// Optional TRIG_TIMEOUT_EN adds an auto-trigger after to_limit armed writes.
module capture_ctrl
  import la_cap_pkg::*;
#(
  parameter int ENTRIES = 384,
  parameter int ADDR_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              abort,
  input  logic              wrt_smpl,
  input  logic              trig,
  input  logic [ADDR_W-1:0] trig_pos,
`ifdef TRIG_TIMEOUT_EN
  input  logic [TO_W-1:0]   to_limit,
  output logic              auto_trig,
`endif
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              set_armed,
  output logic              armed,
  output logic              triggered,
  output logic              capture_done,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam logic [ADDR_W:0]   ENT_X  = (ADDR_W + 1)'(ENTRIES);
  localparam logic [ADDR_W-1:0] TP_MAX = ADDR_W'(ENTRIES - 1);

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              set_armed_q, set_armed_d;
  logic [ADDR_W-1:0] tp;
  logic [ADDR_W:0]   pre_target, pre_next_x;
  logic              start, wr_ok, trig_eff, to_hit, pre_hit;

  always_comb begin
    tp = trig_pos;
    if (trig_pos == '0)                tp = ADDR_W'(1);
    else if ({1'b0, trig_pos} >= ENT_X) tp = TP_MAX;
  end

  assign pre_target = ENT_X - {1'b0, tp};
  assign pre_next_x = {1'b0, pre_cnt_q} + (ADDR_W + 1)'(1);
  assign pre_hit    = (pre_next_x == pre_target);
  assign start      = run & ~abort & ((state_q == IDLE) | (state_q == DONE));
  assign wr_ok      = wrt_smpl & ~abort & ~rst;
  assign trig_eff   = trig | to_hit;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (run)           state_d = PRETRIG;
        PRETRIG:    if (we && pre_hit) state_d = ARMED;
        ARMED:      if (trig_eff)      state_d = POSTTRIG;
        POSTTRIG:   if (post_cnt_q == '0) state_d = DONE;
        default:                       state_d = IDLE;
      endcase
    end
  end

  // Once post_cnt is exhausted the closing POSTTRIG cycle must not write.
  always_comb begin
    we           = 1'b0;
    armed        = 1'b0;
    triggered    = 1'b0;
    capture_done = 1'b0;
    case (state_q)
      PRETRIG:  we = wr_ok;
      ARMED:    begin we = wr_ok; armed = 1'b1; end
      POSTTRIG: begin we = wr_ok & (post_cnt_q != '0); triggered = 1'b1; end
      DONE:     begin triggered = 1'b1; capture_done = 1'b1; end
      default:  ;
    endcase
  end

  always_comb begin
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    set_armed_d = (state_d == ARMED) && (state_q != ARMED);
    if (start) begin
      pre_cnt_d   = '0;
      post_cnt_d  = '0;
      trig_addr_d = '0;
    end else if (!abort) begin
      case (state_q)
        PRETRIG:  if (we) pre_cnt_d = pre_cnt_q + ADDR_W'(1);
        ARMED: if (trig_eff) begin
          trig_addr_d = waddr;
          post_cnt_d  = tp - ADDR_W'(we);
        end
        POSTTRIG: if (we) post_cnt_d = post_cnt_q - ADDR_W'(1);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      set_armed_q <= 1'b0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      set_armed_q <= set_armed_d;
    end
  end

`ifdef TRIG_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            auto_trig_q, auto_trig_d;

  assign to_hit = (state_q == ARMED) && (to_limit != '0) && (to_cnt_q == to_limit);

  always_comb begin
    to_cnt_d    = to_cnt_q;
    auto_trig_d = auto_trig_q;
    if (state_d == ARMED && state_q != ARMED) to_cnt_d = '0;
    else if (state_q == ARMED && we)          to_cnt_d = to_cnt_q + TO_W'(1);
    if (start || abort) auto_trig_d = 1'b0;
    else if (to_hit)    auto_trig_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q    <= '0;
      auto_trig_q <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      auto_trig_q <= auto_trig_d;
    end
  end

  assign auto_trig = auto_trig_q;
`else
  assign to_hit = 1'b0;
`endif

  wrap_ctr #(.MOD(ENTRIES), .W(ADDR_W)) u_waddr (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .inc (we),
    .cnt (waddr)
  );

  assign set_armed = set_armed_q;
  assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: expected write addresses queued at strobe time, popped on we.
module tb_capture_ctrl;

  localparam int ENTRIES = 16;
  localparam int AW      = 5;

  logic          clk = 1'b0;
  logic          rst, run, abort, wrt_smpl, trig;
  logic [AW-1:0] trig_pos;
  logic          we, set_armed, armed, triggered, capture_done;
  logic [AW-1:0] waddr, trig_addr;
`ifdef TRIG_TIMEOUT_EN
  logic [15:0]   to_limit;
  logic          auto_trig;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int m_addr   = 0;

  always #5 clk = ~clk;

  capture_ctrl #(.ENTRIES(ENTRIES), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .abort        (abort),
    .wrt_smpl     (wrt_smpl),
    .trig         (trig),
    .trig_pos     (trig_pos),
`ifdef TRIG_TIMEOUT_EN
    .to_limit     (to_limit),
    .auto_trig    (auto_trig),
`endif
    .we           (we),
    .waddr        (waddr),
    .set_armed    (set_armed),
    .armed        (armed),
    .triggered    (triggered),
    .capture_done (capture_done),
    .trig_addr    (trig_addr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && we === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_we", 1, 0);
      else                   chk("waddr", waddr, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr();
    exp_q.push_back(m_addr);
    m_addr = (m_addr + 1) % ENTRIES;
  endtask

  task automatic strobe(input bit t);
    wrt_smpl = 1'b1;
    trig     = t;
    tick();
    wrt_smpl = 1'b0;
    trig     = 1'b0;
    repeat (3) tick();
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
    run    = 1'b0;
    m_addr = 0;
  endtask

  task automatic pre_fill(input int npre, input bit pre_trig);
    for (int i = 0; i < npre - 1; i++) begin
      push_wr();
      strobe(1'b0);
      if (pre_trig) begin
        trig = 1'b1;
        tick();
        trig = 1'b0;
      end
    end
    chk("pre_not_armed", armed, 0);
    push_wr();
    wrt_smpl = 1'b1;
    tick();
    wrt_smpl = 1'b0;
    chk("set_armed_first", set_armed, 1);
    chk("armed_first", armed, 1);
    tick();
    chk("set_armed_pulse", set_armed, 0);
    chk("armed_held", armed, 1);
    repeat (2) tick();
  endtask

  task automatic capture(input int tp_raw, input int tp_eff, input bit pre_trig,
                         input int armed_n, input bit coinc, input bit run_post);
    int exp_ta;
    int npost;
    trig_pos = AW'(tp_raw);
    start_run();
    chk("start_flags", {armed, triggered, capture_done, set_armed}, 0);
    chk("start_waddr", waddr, 0);
    chk("start_trig_addr", trig_addr, 0);
    pre_fill(ENTRIES - tp_eff, pre_trig);
    for (int i = 0; i < armed_n; i++) begin
      push_wr();
      strobe(1'b0);
    end
    chk("armed_wait", armed, 1);
    exp_ta = m_addr;
    if (coinc) begin
      push_wr();
      strobe(1'b1);
      npost = tp_eff - 1;
    end else begin
      trig = 1'b1;
      tick();
      trig  = 1'b0;
      npost = tp_eff;
    end
    chk("triggered", triggered, 1);
    chk("trig_addr", trig_addr, exp_ta);
    for (int i = 0; i < npost; i++) begin
      if (run_post && i == npost - 1) begin
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("run_in_post_ignored", triggered, 1);
      end
      push_wr();
      strobe(1'b0);
    end
    chk("done", capture_done, 1);
    chk("done_triggered", triggered, 1);
    chk("done_armed", armed, 0);
    chk("final_waddr", waddr, m_addr);
    chk("all_writes_seen", exp_q.size(), 0);
    strobe(1'b1);
    chk("done_trig_addr_held", trig_addr, exp_ta);
    chk("done_held", capture_done, 1);
    chk("done_waddr_frozen", waddr, m_addr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    run      = 1'b1;
    abort    = 1'b0;
    wrt_smpl = 1'b1;
    trig     = 1'b0;
    trig_pos = AW'(4);
`ifdef TRIG_TIMEOUT_EN
    to_limit = 16'd0;
`endif
    repeat (3) tick();
    chk("rst_flags", {we, set_armed, armed, triggered, capture_done}, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_trig_addr", trig_addr, 0);
    rst      = 1'b0;
    run      = 1'b0;
    wrt_smpl = 1'b0;
    tick();
    strobe(1'b0);
    strobe(1'b1);
    chk("idle_needs_run", {armed, triggered, capture_done}, 0);

    // Main capture with trig noise in PRETRIG and a trig coincident with a strobe.
    capture(4, 4, 1'b1, 0, 1'b1, 1'b0);

    // Arm with no trig long enough to wrap repeatedly, then abort mid-strobe.
    trig_pos = AW'(4);
    start_run();
    pre_fill(12, 1'b0);
    for (int i = 0; i < 40; i++) begin
      push_wr();
      strobe(1'b0);
    end
    chk("long_armed", armed, 1);
    chk("long_waddr", waddr, m_addr);
    wrt_smpl = 1'b1;
    abort    = 1'b1;
    #1;
    chk("abort_we", we, 0);
    tick();
    wrt_smpl = 1'b0;
    abort    = 1'b0;
    chk("abort_flags", {set_armed, armed, triggered, capture_done}, 0);
    chk("abort_no_pending", exp_q.size(), 0);
    repeat (3) tick();

    // Clamp low (0 -> 1) with run during POSTTRIG, then clamp high (20 -> 15).
    capture(0, 1, 1'b0, 0, 1'b0, 1'b1);
    capture(20, 15, 1'b0, 2, 1'b1, 1'b0);

    // abort beats run in DONE.
    run   = 1'b1;
    abort = 1'b1;
    tick();
    run   = 1'b0;
    abort = 1'b0;
    chk("abort_beats_run", {armed, triggered, capture_done}, 0);
    strobe(1'b0);
    chk("abort_beats_run_idle", {armed, triggered, capture_done}, 0);

`ifdef TRIG_TIMEOUT_EN
    trig_pos = AW'(4);
    to_limit = 16'd5;
    start_run();
    chk("to_auto_clear_start", auto_trig, 0);
    pre_fill(12, 1'b0);
    for (int i = 0; i < 5; i++) begin
      push_wr();
      strobe(1'b0);
    end
    chk("to_triggered", triggered, 1);
    chk("to_auto_trig", auto_trig, 1);
    chk("to_trig_addr", trig_addr, m_addr);
    for (int i = 0; i < 4; i++) begin
      push_wr();
      strobe(1'b0);
    end
    chk("to_done", capture_done, 1);
    chk("to_auto_sticky", auto_trig, 1);
    to_limit = 16'd0;
    start_run();
    chk("to_auto_cleared_by_run", auto_trig, 0);
    pre_fill(12, 1'b0);
    for (int i = 0; i < 10; i++) begin
      push_wr();
      strobe(1'b0);
    end
    chk("to_disabled_armed", armed, 1);
    chk("to_disabled_no_auto", auto_trig, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("to_abort_idle", armed, 0);
`endif

    repeat (4) tick();
    chk("end_no_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
